// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, FSM states and instruction field positions
package proc_pkg;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RA_MSB  = 3;
    localparam int RA_LSB  = 2;
    localparam int RB_MSB  = 1;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WAIT,
        S_HALTED
    } state_t;

endpackage

// File: rtl/proc_decode.sv
// rtl/proc_decode.sv - combinational split of the instruction register into fields and opcode flags
module proc_decode
    import proc_pkg::*;
(
    input  logic [7:0] ir_i,
    output logic [1:0] rd_o,
    output logic [1:0] ra_o,
    output logic [1:0] rb_o,
    output logic [3:0] imm_o,
    output logic       is_ldi_o,
    output logic       is_halt_o,
    output logic       is_jmp_o,
    output logic       is_add_o
);

    logic [1:0] opcode;

    assign opcode    = ir_i[OP_MSB:OP_LSB];
    assign rd_o      = ir_i[RD_MSB:RD_LSB];
    assign ra_o      = ir_i[RA_MSB:RA_LSB];
    assign rb_o      = ir_i[RB_MSB:RB_LSB];
    assign imm_o     = ir_i[IMM_MSB:IMM_LSB];

    assign is_ldi_o  = (opcode == OP_LDI);
    assign is_halt_o = (opcode == OP_HALT);
    assign is_jmp_o  = (opcode == OP_JMP);
    assign is_add_o  = (opcode == OP_ADD);

endmodule

// File: rtl/proc_seq.sv
// rtl/proc_seq.sv - fetch/decode/execute sequencer owning the PC, three cycles per instruction
module proc_seq
    import proc_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'd0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_en,
    input  logic       step,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic       wsel_imm,
    output logic [3:0] imm,
    output logic       alu_add,
    output logic [3:0] pc,
    output logic       busy,
    output logic       halted
);

    state_t     state_q;
    logic [3:0] pc_q;
    logic [7:0] ir_q;

    logic [1:0] dec_rd;
    logic [1:0] dec_ra;
    logic [1:0] dec_rb;
    logic [3:0] dec_imm;
    logic       is_ldi;
    logic       is_halt;
    logic       is_jmp;
    logic       is_add;

    proc_decode u_decode (
        .ir_i      (ir_q),
        .rd_o      (dec_rd),
        .ra_o      (dec_ra),
        .rb_o      (dec_rb),
        .imm_o     (dec_imm),
        .is_ldi_o  (is_ldi),
        .is_halt_o (is_halt),
        .is_jmp_o  (is_jmp),
        .is_add_o  (is_add)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q    <= RESET_PC;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_q    <= rom_data;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_halt) begin
                        state_q <= S_HALTED;
                    end else begin
                        pc_q    <= is_jmp ? dec_imm : pc_q + 4'd1;
                        state_q <= step_en ? S_WAIT : S_FETCH;
                    end
                end
                // Dropping step_en while parked behaves like an implicit step.
                S_WAIT: begin
                    if (!step_en || step) begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        pc_q    <= RESET_PC;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Every output decodes from state_q/ir_q/pc_q; rom_data only ever reaches ir_q.
    assign rom_addr   = pc_q;
    assign pc         = pc_q;
    assign rf_raddr_a = dec_ra;
    assign rf_raddr_b = dec_rb;
    assign rf_waddr   = dec_rd;
    assign imm        = dec_imm;
    assign rf_we      = (state_q == S_EXECUTE) && (is_ldi || is_add);
    assign wsel_imm   = (state_q == S_EXECUTE) && is_ldi;
    assign alu_add    = (state_q == S_EXECUTE) && is_add;
    assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || (state_q == S_WAIT);
    assign halted     = (state_q == S_HALTED);

endmodule

// File: doc/proc_seq.md
# proc_seq

Fetch/decode/execute sequencer for the 4-bit processor. It drives the 4-bit instruction ROM address, latches the 8-bit instruction, and decodes it. It issues register-file and ALU control for one instruction every three cycles, and stops on HALT. It sits between the instruction ROM and the register file/ALU datapath and is the only owner of the program counter.

## Interface
- RESET_PC, 4'd0, PC value loaded on reset and on `start`
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  one-cycle pulse; from IDLE or HALTED: PC := RESET_PC, begin fetching
- step_en  in  1  1 = single-step mode (execute one instruction per `step` pulse); 0 = free-run
- step  in  1  one-cycle pulse; permits one instruction in single-step mode
- rom_addr  out  4  instruction address (= PC)
- rom_data  in  8  instruction from combinational ROM, valid same cycle as rom_addr
- rf_raddr_a  out  2  register-file read port A address
- rf_raddr_b  out  2  register-file read port B address
- rf_we  out  1  register-file write strobe, one cycle per writing instruction
- rf_waddr  out  2  register-file write address
- wsel_imm  out  1  1 = write immediate, 0 = write ALU result
- imm  out  4  zero-extended immediate field
- alu_add  out  1  ALU add enable (ADD instruction in EXECUTE)
- pc  out  4  current program counter (debug)
- busy  out  1  high in FETCH/DECODE/EXECUTE/WAIT
- halted  out  1  high in HALTED

## Operation
- Instruction format, IR[7:6] = opcode:
  - 00 LDI: rd = IR[5:4], imm = IR[3:0]
  - 01 HALT: remaining bits ignored
  - 10 JMP: target = IR[3:0]
  - 11 ADD: rd = IR[5:4], ra = IR[3:2], rb = IR[1:0], giving rd := ra + rb (4-bit, carry discarded)
- States are IDLE, FETCH, DECODE, EXECUTE, WAIT, HALTED.
- IDLE --start--> FETCH.
- FETCH: rom_addr = pc. At the end of the cycle, IR := rom_data. Next state is DECODE.
- DECODE: drive rf_raddr_a = IR[3:2] and rf_raddr_b = IR[1:0] for all opcodes. Next state is EXECUTE.
- EXECUTE, per opcode:
  - LDI: rf_we = 1, wsel_imm = 1, rf_waddr = rd, imm = IR[3:0]; pc := pc+1.
  - ADD: rf_we = 1, wsel_imm = 0, alu_add = 1, rf_waddr = rd; read addresses held; pc := pc+1.
  - JMP: pc := IR[3:0], no write.
  - HALT: no write, pc unchanged; next state HALTED.
- After EXECUTE (non-HALT): if step_en = 0 go to FETCH, else go to WAIT.
- WAIT --step--> FETCH. `step` outside WAIT is ignored. Clearing step_en while in WAIT resumes FETCH next cycle.
- HALTED --start--> FETCH with pc := RESET_PC. `start` while busy is ignored.
- PC arithmetic is modulo 16: 15+1 wraps to 0.
- rf_we, alu_add and wsel_imm are 0 outside EXECUTE. imm and rf_waddr reflect IR at all times.

## Timing
- Reset (async, immediate) sets:
  - state = IDLE, pc = RESET_PC, IR = 8'h00
  - all strobes 0, busy = 0, halted = 0
  - rom_addr = RESET_PC, rf_raddr_a/b = 0, imm = 0, rf_waddr = 0
- Reset asserted mid-instruction aborts it. No rf_we is issued after rst rises.
- All outputs are registered or decoded from registered state/IR only. There is no combinational path rom_data -> outputs.
- Free-run timing: 3 cycles per instruction.
  - start at cycle 0 → FETCH at cycle 1, DECODE at 2, EXECUTE (rf_we) at 3, next FETCH at 4.
- The register file writes on the rising edge that ends EXECUTE. Read-after-write between consecutive instructions is therefore safe with no forwarding.
- halted rises the cycle after HALT's EXECUTE.

## Structure
- A shared package `proc_pkg` holds:
  - opcode constants: OP_LDI = 2'b00, OP_HALT = 2'b01, OP_JMP = 2'b10, OP_ADD = 2'b11
  - the state enum
  - field-slice localparams
- One combinational sub-module, `proc_decode` (IR → rd/ra/rb/imm/opcode flags), is natural. The FSM and PC stay in `proc_seq`.

## Test plan
- **Load and add, free-run:** ROM = 01h, 11h, 21h, 31h, C4h, C8h, CCh, 40h; step_en = 0; pulse start.
  - First four EXECUTEs: rf_we with rf_waddr = 0,1,2,3, imm = 1.
  - ADD EXECUTEs: (ra, rb) = (1,0), (2,0), (3,0).
  - halted rises at cycle 25; pc = 7.
- **Jump and wrap:**
  - ROM[0] = 82h: after EXECUTE, pc = 2.
  - ROM at 15 = LDI: pc wraps to 0.
- **Single-step:** step_en = 1, start.
  - FSM parks in WAIT after each EXECUTE.
  - Each step pulse yields exactly one rf_we 3 cycles later.
  - step held idle for 10 cycles gives no progress.
- **Reset mid-operation:** assert rst during the DECODE of an ADD.
  - rf_we never asserts.
  - All outputs equal reset values in the same cycle.
  - After release, start restarts at pc = 0.
- **Restart after halt:**
  - start in HALTED → FETCH at RESET_PC, halted drops next cycle.
  - start during busy is ignored (pc is not reloaded).
